// File: rtl/pixel_batch_dispatcher.sv
// Raster-order pixel dispatcher: each accepted batch carries NUM_ENGINES consecutive pixels of a runtime-sized frame.
// Optional performance counters are enabled with the PIXEL_DISPATCH_PERF_EN macro.
`timescale 1ns/1ps
module pixel_batch_dispatcher #(
  parameter int COORD_WIDTH = 16,
  parameter int NUM_ENGINES = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [COORD_WIDTH-1:0] cfg_width,
  input  logic [COORD_WIDTH-1:0] cfg_height,
  output logic                   batch_valid,
  input  logic                   batch_ready,
  output logic [NUM_ENGINES-1:0] lane_valid,
  output logic [COORD_WIDTH-1:0] job_x [NUM_ENGINES],
  output logic [COORD_WIDTH-1:0] job_y [NUM_ENGINES],
  output logic                   busy,
  output logic                   frame_done,
  output logic                   cfg_err
`ifdef PIXEL_DISPATCH_PERF_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [15:0]            frame_count
`endif
);

  localparam int XW = COORD_WIDTH + 1;
  localparam logic [XW-1:0] N_EXT = XW'(NUM_ENGINES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [COORD_WIDTH-1:0] x0_q, x0_d, y0_q, y0_d;
  logic [COORD_WIDTH-1:0] w_q, w_d, h_q, h_d;
  logic                   batch_valid_q, batch_valid_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic                   cfg_err_q, cfg_err_d;

  logic [XW-1:0] w_ext, h_ext, x_adv;
  logic          run, cfg_ok, start_accept, handshake, row_wrap, last_batch;

  assign run          = (state_q == RUN);
  assign w_ext        = {1'b0, w_q};
  assign h_ext        = {1'b0, h_q};
  assign cfg_ok       = ({1'b0, cfg_width} >= N_EXT) && (cfg_height != '0);
  assign start_accept = !run && start && !abort && cfg_ok;
  assign handshake    = batch_valid_q && batch_ready;
  assign x_adv        = {1'b0, x0_q} + N_EXT;
  assign row_wrap     = (x_adv >= w_ext);
  // Width >= lane count guarantees a batch spans at most two rows.
  assign last_batch   = (y0_q == h_q - COORD_WIDTH'(1)) && row_wrap;

  generate
    for (genvar gi = 0; gi < NUM_ENGINES; gi++) begin : g_lane
      logic [XW-1:0]          x_raw, y_lane;
      logic [COORD_WIDTH-1:0] x_lane;

      assign x_raw = {1'b0, x0_q} + XW'(gi);

      always_comb begin
        x_lane = COORD_WIDTH'(x_raw);
        y_lane = {1'b0, y0_q};
        if (x_raw >= w_ext) begin
          x_lane = COORD_WIDTH'(x_raw - w_ext);
          y_lane = {1'b0, y0_q} + XW'(1);
        end
      end

      // Lanes past the frame end still carry coordinates; only lane_valid drops.
      assign job_x[gi]      = run ? x_lane : '0;
      assign job_y[gi]      = run ? y_lane[COORD_WIDTH-1:0] : '0;
      assign lane_valid[gi] = run && (y_lane < h_ext);
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    w_d          = w_q;
    h_d          = h_q;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (cfg_ok) begin
            w_d     = cfg_width;
            h_d     = cfg_height;
            x0_d    = '0;
            y0_d    = '0;
            state_d = RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (handshake) begin
          if (last_batch) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end else if (row_wrap) begin
            x0_d = COORD_WIDTH'(x_adv - w_ext);
            y0_d = y0_q + COORD_WIDTH'(1);
          end else begin
            x0_d = COORD_WIDTH'(x_adv);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    batch_valid_d = (state_d == RUN);
    busy_d        = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      x0_q          <= '0;
      y0_q          <= '0;
      w_q           <= '0;
      h_q           <= '0;
      batch_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      x0_q          <= x0_d;
      y0_q          <= y0_d;
      w_q           <= w_d;
      h_q           <= h_d;
      batch_valid_q <= batch_valid_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign batch_valid = batch_valid_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign cfg_err     = cfg_err_q;

`ifdef PIXEL_DISPATCH_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [15:0] fcount_q, fcount_d;

  always_comb begin
    stall_d  = stall_q;
    fcount_d = fcount_q;
    if (start_accept) begin
      stall_d = '0;
    end else if (run && batch_valid_q && !batch_ready) begin
      stall_d = stall_q + 32'd1;
    end
    if (frame_done_d) begin
      fcount_d = fcount_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q  <= '0;
      fcount_q <= '0;
    end else begin
      stall_q  <= stall_d;
      fcount_q <= fcount_d;
    end
  end

  assign stall_cycles = stall_q;
  assign frame_count  = fcount_q;
`endif

endmodule
